// File: rtl/fix_tag_search_if.sv
// ---------------------------------------------------------------------------
// fix_tag_search_if
// Bundles the search request, the message-buffer read port and the result
// signals of the FIX tag-lookup engine.
//   slave  : the tag-search engine (consumes request/read data, drives
//            read port and results)
//   master : the requester together with the message buffer (drives the
//            request and read data, observes read port and results)
// Signal names keep the engine's point of view (_i into the engine,
// _o out of it).
// ---------------------------------------------------------------------------
interface fix_tag_search_if #(
  parameter int TAG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
);
  // Search request
  logic                  search_tag_i;
  logic [TAG_WIDTH-1:0]  tag_i;
  logic [ADDR_WIDTH-1:0] start_addr_i;
  logic [ADDR_WIDTH-1:0] end_addr_i;
  // Message-buffer read port
  logic                  mem_rd_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [7:0]            mem_rd_data_i;
  // Status and results
  logic                  busy_o;
  logic                  done_o;
  logic                  found_o;
  logic                  error_o;
  logic [ADDR_WIDTH-1:0] value_start_o;
  logic [ADDR_WIDTH-1:0] value_len_o;

  modport slave (
    input  search_tag_i, tag_i, start_addr_i, end_addr_i, mem_rd_data_i,
    output mem_rd_en_o, mem_addr_o, busy_o, done_o, found_o, error_o,
           value_start_o, value_len_o
  );

  modport master (
    output search_tag_i, tag_i, start_addr_i, end_addr_i, mem_rd_data_i,
    input  mem_rd_en_o, mem_addr_o, busy_o, done_o, found_o, error_o,
           value_start_o, value_len_o
  );
endinterface

// File: rtl/fix_tag_search.sv
// ---------------------------------------------------------------------------
// fix_tag_search
// Scans one stored FIX message (inclusive byte range start..end of the
// message buffer) for the first "tag=value<SOH>" field whose decimal tag
// equals the requested binary tag, and reports where its value lives.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts a scan, no done pulse)
//   bus  - fix_tag_search_if.slave:
//            search_tag_i/tag_i/start_addr_i/end_addr_i : request (IDLE only)
//            mem_rd_en_o/mem_addr_o/mem_rd_data_i       : buffer read port,
//                                                         1-cycle read latency
//            busy_o/done_o                               : status
//            found_o/error_o/value_start_o/value_len_o  : results, held from
//                                                         done_o until the next
//                                                         accepted request
//
// Read pipeline: one address is issued per cycle; the byte for the address
// issued in cycle c is parsed in cycle c+1. Because issue runs one byte
// ahead of parsing, termination can leave one read in flight; its data is
// simply never looked at.
// ---------------------------------------------------------------------------
module fix_tag_search #(
  parameter int TAG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic            clk,
  input logic            rst,
  fix_tag_search_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN_TAG,
    S_SCAN_VALUE,
    S_FINISH
  } state_e;

  localparam logic [7:0] CH_SOH  = 8'h01;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;

  // Control
  state_e                state_q,      state_d;
  logic                  bad_range_q,  bad_range_d;
  // Latched request
  logic [TAG_WIDTH-1:0]  tag_q,        tag_d;
  logic [ADDR_WIDTH-1:0] end_q,        end_d;
  // Parser state
  logic [TAG_WIDTH-1:0]  acc_q,        acc_d;
  logic                  digit_seen_q, digit_seen_d;
  logic                  match_q,      match_d;
  // Read issue and returning-byte tracking
  logic                  rd_en_q,      rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
  logic                  byte_vld_q,   byte_vld_d;
  logic [ADDR_WIDTH-1:0] byte_addr_q,  byte_addr_d;
  // Results
  logic                  found_q,      found_d;
  logic                  error_q,      error_d;
  logic [ADDR_WIDTH-1:0] vstart_q,     vstart_d;
  logic [ADDR_WIDTH-1:0] vlen_q,       vlen_d;

  // Byte decode
  logic [7:0] cur_byte;
  logic       is_digit;
  logic       scan_done;

  assign cur_byte = bus.mem_rd_data_i;
  assign is_digit = (cur_byte >= CH_ZERO) && (cur_byte <= CH_NINE);

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    bad_range_d  = bad_range_q;
    tag_d        = tag_q;
    end_d        = end_q;
    acc_d        = acc_q;
    digit_seen_d = digit_seen_q;
    match_d      = match_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    byte_vld_d   = 1'b0;
    byte_addr_d  = byte_addr_q;
    found_d      = found_q;
    error_d      = error_q;
    vstart_d     = vstart_q;
    vlen_d       = vlen_q;
    scan_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.search_tag_i) begin
          tag_d        = bus.tag_i;
          end_d        = bus.end_addr_i;
          acc_d        = '0;
          digit_seen_d = 1'b0;
          match_d      = 1'b0;
          found_d      = 1'b0;
          error_d      = 1'b0;
          vstart_d     = '0;
          vlen_d       = '0;
          bad_range_d  = bus.start_addr_i > bus.end_addr_i;
          // An inverted range spends one busy cycle in SCAN_TAG without
          // reading anything, so its done pulse lines up one cycle later.
          rd_en_d      = !(bus.start_addr_i > bus.end_addr_i);
          rd_addr_d    = bus.start_addr_i;
          state_d      = S_SCAN_TAG;
        end
      end

      S_SCAN_TAG, S_SCAN_VALUE: begin
        if (bad_range_q) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          // Keep one read in flight; stop issuing after end address.
          byte_vld_d  = rd_en_q;
          byte_addr_d = rd_addr_q;
          if (rd_en_q && (rd_addr_q != end_q)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          end

          if (byte_vld_q) begin
            if (state_q == S_SCAN_TAG) begin
              if (is_digit) begin
                // Decimal accumulate, wrapping modulo 2^TAG_WIDTH.
                acc_d        = (acc_q * TAG_WIDTH'(10)) + TAG_WIDTH'(cur_byte[3:0]);
                digit_seen_d = 1'b1;
              end else if ((cur_byte == CH_EQ) && digit_seen_q) begin
                match_d  = (acc_q == tag_q);
                vstart_d = byte_addr_q + ADDR_WIDTH'(1);
                vlen_d   = '0;
                state_d  = S_SCAN_VALUE;
              end else begin
                // Non-digit in a tag, or '=' with no digits before it.
                error_d   = 1'b1;
                found_d   = 1'b0;
                scan_done = 1'b1;
              end
            end else begin
              if (cur_byte == CH_SOH) begin
                if (match_q) begin
                  found_d   = 1'b1;
                  scan_done = 1'b1;
                end else begin
                  acc_d        = '0;
                  digit_seen_d = 1'b0;
                  state_d      = S_SCAN_TAG;
                end
              end else begin
                vlen_d = vlen_q + ADDR_WIDTH'(1);
              end
            end

            // Message exhausted without an explicit terminator: only an
            // open matching value counts as found; everything else is a
            // clean miss (including a trailing partial tag).
            if (!scan_done && (byte_addr_q == end_q)) begin
              found_d   = (state_d == S_SCAN_VALUE) && match_d;
              scan_done = 1'b1;
            end
          end

          if (scan_done) begin
            rd_en_d    = 1'b0;
            byte_vld_d = 1'b0;
            state_d    = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      bad_range_q  <= 1'b0;
      tag_q        <= '0;
      end_q        <= '0;
      acc_q        <= '0;
      digit_seen_q <= 1'b0;
      match_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      byte_vld_q   <= 1'b0;
      byte_addr_q  <= '0;
      found_q      <= 1'b0;
      error_q      <= 1'b0;
      vstart_q     <= '0;
      vlen_q       <= '0;
    end else begin
      state_q      <= state_d;
      bad_range_q  <= bad_range_d;
      tag_q        <= tag_d;
      end_q        <= end_d;
      acc_q        <= acc_d;
      digit_seen_q <= digit_seen_d;
      match_q      <= match_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      byte_vld_q   <= byte_vld_d;
      byte_addr_q  <= byte_addr_d;
      found_q      <= found_d;
      error_q      <= error_d;
      vstart_q     <= vstart_d;
      vlen_q       <= vlen_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.mem_rd_en_o   = rd_en_q;
  assign bus.mem_addr_o    = rd_addr_q;
  assign bus.busy_o        = (state_q == S_SCAN_TAG) || (state_q == S_SCAN_VALUE);
  assign bus.done_o        = (state_q == S_FINISH);
  assign bus.found_o       = found_q;
  assign bus.error_o       = error_q;
  assign bus.value_start_o = vstart_q;
  assign bus.value_len_o   = vlen_q;

endmodule

// File: tb/tb_fix_tag_search.sv
// ---------------------------------------------------------------------------
// tb_fix_tag_search
// Self-checking bench for fix_tag_search: a table of directed searches over
// hand-built messages, hand-written sequences for reset abort and ignored
// strobes, and random messages checked against a field-level parser model.
// Cycle numbering: the strobe is high in cycle 0; cycle n is the interval
// after the n-th rising edge that follows. Outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_fix_tag_search;

  localparam int TW = 32;
  localparam int AW = 10;

  typedef struct {
    bit found;
    bit error;
    int vstart;
    int vlen;
    int done_cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] tag;
    int          s;
    int          e;
    exp_t        x;
  } vec_t;

  typedef struct {
    int done_cyc;
    bit found;
    bit error;
    int vstart;
    int vlen;
    bit busy_ok;
    bit reads_ok;
    bit done_after;
    int n_reads;
  } obs_t;

  logic clk;
  logic rst;
  logic [7:0] mem [0:1023];

  int n_checks;
  int n_pass;

  fix_tag_search_if #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW)) bus ();

  fix_tag_search #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Message buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_addr_o];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // '|' stands for SOH in message text.
  task automatic load(input int base, input string s);
    for (int i = 0; i < s.len(); i++) mem[base + i] = (s[i] == "|") ? 8'h01 : s[i];
  endtask

  // Field-level reference: walk fields "digits '=' value SOH" and decide
  // the outcome from where the first bad tag byte, the first matching tag
  // and the message end fall.
  function automatic exp_t model(input logic [31:0] tag, input int s, input int e);
    exp_t x;
    int pos, soh, nd;
    longint unsigned tv;
    x = '{default: 0};
    if (s > e) begin
      x.error = 1'b1;
      x.done_cyc = 2;
      return x;
    end
    x.done_cyc = e - s + 3;
    pos = s;
    while (pos <= e) begin
      tv = 0;
      nd = 0;
      while (pos <= e && mem[pos] >= 8'h30 && mem[pos] <= 8'h39) begin
        tv = (tv * 10 + longint'(mem[pos] - 8'h30)) & 64'hFFFF_FFFF;
        nd++;
        pos++;
      end
      if (pos > e) return x;
      if (mem[pos] != 8'h3D || nd == 0) begin
        x.error = 1'b1;
        x.done_cyc = pos - s + 3;
        return x;
      end
      soh = pos + 1;
      while (soh <= e && mem[soh] != 8'h01) soh++;
      if (tv == longint'(tag)) begin
        x.found  = 1'b1;
        x.vstart = pos + 1;
        x.vlen   = soh - pos - 1;
        if (soh <= e) x.done_cyc = soh - s + 3;
        return x;
      end
      pos = soh + 1;
    end
    return x;
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] t, input int s, input int e,
                              input bit f, input bit er, input int vs, input int vl, input int dc);
    vec_t v;
    v.name = n; v.tag = t; v.s = s; v.e = e;
    v.x.found = f; v.x.error = er; v.x.vstart = vs; v.x.vlen = vl; v.x.done_cyc = dc;
    return v;
  endfunction

  task automatic run_search(input logic [31:0] tag, input int s, input int e, output obs_t o);
    logic [AW-1:0] sa, ea;
    o = '{default: 0};
    o.done_cyc = -1;
    o.busy_ok  = 1'b1;
    o.reads_ok = 1'b1;
    sa = s[AW-1:0];
    ea = e[AW-1:0];
    bus.search_tag_i = 1'b1;
    bus.tag_i        = tag;
    bus.start_addr_i = sa;
    bus.end_addr_i   = ea;
    @(posedge clk); #1;
    bus.search_tag_i = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (bus.mem_rd_en_o) begin
        o.n_reads++;
        if (int'(bus.mem_addr_o) < s || int'(bus.mem_addr_o) > e) o.reads_ok = 1'b0;
      end
      if (bus.done_o) begin
        o.done_cyc = c;
        o.found    = bus.found_o;
        o.error    = bus.error_o;
        o.vstart   = int'(bus.value_start_o);
        o.vlen     = int'(bus.value_len_o);
        if (bus.busy_o) o.busy_ok = 1'b0;
        break;
      end
      if (!bus.busy_o) o.busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    o.done_after = bus.done_o;
  endtask

  task automatic expect_result(input string n, input obs_t o, input exp_t x, input int s, input int e);
    check({n, ".done_cycle"}, o.done_cyc, x.done_cyc);
    check({n, ".found"},      o.found,    x.found);
    check({n, ".error"},      o.error,    x.error);
    if (x.found) begin
      check({n, ".value_start"}, o.vstart, x.vstart);
      check({n, ".value_len"},   o.vlen,   x.vlen);
    end
    check({n, ".busy_window"}, o.busy_ok,    1);
    check({n, ".read_range"},  o.reads_ok,   1);
    check({n, ".done_pulse"},  o.done_after, 0);
    if (s > e) check({n, ".no_reads"}, o.n_reads, 0);
  endtask

  vec_t vecs [11];

  initial begin
    obs_t o;
    exp_t x;
    int   base, p, nf, e, vl, dc, ndone;
    bit   saw_done, busy_after;
    logic [31:0] tags [5];
    logic [31:0] tgt;
    string ts;

    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h20;
    bus.search_tag_i  = 1'b0;
    bus.tag_i         = '0;
    bus.start_addr_i  = '0;
    bus.end_addr_i    = '0;
    bus.mem_rd_data_i = '0;

    load(12'h000, "8=FIX.4.2|35=D|49=ABC|");
    load(12'h100, "58=|");
    load(12'h110, "3a=X|");
    load(12'h120, "=5|");
    load(12'h130, "7=XY");
    load(12'h140, "12=A|34");
    load(12'h150, "4294967297=Z|");

    vecs[0]  = mk("tag35",       35, 0,     21,    1, 0, 13,    1, 17);
    vecs[1]  = mk("tag49",       49, 0,     21,    1, 0, 18,    3, 24);
    vecs[2]  = mk("tag52_miss",  52, 0,     21,    0, 0, 0,     0, 24);
    vecs[3]  = mk("tag8",        8,  0,     21,    1, 0, 2,     7, 12);
    vecs[4]  = mk("empty_value", 58, 'h100, 'h103, 1, 0, 'h103, 0, 6);
    vecs[5]  = mk("bad_char",    3,  'h110, 'h114, 0, 1, 0,     0, 4);
    vecs[6]  = mk("bad_range",   0,  5,     4,     0, 1, 0,     0, 2);
    vecs[7]  = mk("eq_no_digit", 5,  'h120, 'h122, 0, 1, 0,     0, 3);
    vecs[8]  = mk("value_to_end", 7, 'h130, 'h133, 1, 0, 'h132, 2, 6);
    vecs[9]  = mk("tag_pending", 34, 'h140, 'h146, 0, 0, 0,     0, 9);
    vecs[10] = mk("tag_wrap",    1,  'h150, 'h15C, 1, 0, 'h15B, 1, 15);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.busy",        bus.busy_o,        0);
    check("reset.done",        bus.done_o,        0);
    check("reset.found",       bus.found_o,       0);
    check("reset.error",       bus.error_o,       0);
    check("reset.mem_rd_en",   bus.mem_rd_en_o,   0);
    check("reset.value_start", bus.value_start_o, 0);
    check("reset.value_len",   bus.value_len_o,   0);
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      run_search(vecs[i].tag, vecs[i].s, vecs[i].e, o);
      expect_result(vecs[i].name, o, vecs[i].x, vecs[i].s, vecs[i].e);
    end

    // Reset in cycle 6 of a tag-49 search aborts it silently.
    bus.search_tag_i = 1'b1;
    bus.tag_i        = 49;
    bus.start_addr_i = '0;
    bus.end_addr_i   = 10'd21;
    @(posedge clk); #1;
    bus.search_tag_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort.busy",        bus.busy_o,        0);
    check("rst_abort.done",        bus.done_o,        0);
    check("rst_abort.mem_rd_en",   bus.mem_rd_en_o,   0);
    check("rst_abort.mem_addr",    bus.mem_addr_o,    0);
    check("rst_abort.value_start", bus.value_start_o, 0);
    check("rst_abort.value_len",   bus.value_len_o,   0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done_o) saw_done = 1'b1;
    end
    check("rst_abort.no_done", saw_done, 0);
    run_search(49, 0, 21, o);
    expect_result("after_rst_tag49", o, vecs[1].x, 0, 21);

    // Strobes while busy and during done are ignored.
    bus.search_tag_i = 1'b1;
    bus.tag_i        = 35;
    bus.start_addr_i = '0;
    bus.end_addr_i   = 10'd21;
    @(posedge clk); #1;
    ndone = 0;
    dc = -1;
    busy_after = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      bus.search_tag_i = (c >= 3 && c <= 5);
      bus.tag_i        = (c >= 3 && c <= 5) ? 32'd49 : 32'd35;
      if (dc > 0 && c == dc + 1 && (bus.busy_o || bus.mem_rd_en_o)) busy_after = 1'b1;
      if (bus.done_o) begin
        ndone++;
        if (dc < 0) begin
          dc = c;
          o.found  = bus.found_o;
          o.vstart = int'(bus.value_start_o);
          o.vlen   = int'(bus.value_len_o);
          bus.search_tag_i = 1'b1;
          bus.tag_i        = 32'd49;
        end
      end
      @(posedge clk); #1;
    end
    bus.search_tag_i = 1'b0;
    check("busy_strobe.done_count",  ndone,    1);
    check("busy_strobe.done_cycle",  dc,       17);
    check("busy_strobe.found",       o.found,  1);
    check("busy_strobe.value_start", o.vstart, 13);
    check("busy_strobe.value_len",   o.vlen,   1);
    check("done_strobe.ignored",     busy_after, 0);

    // Random messages against the field-level model
    for (int it = 0; it < 40; it++) begin
      base = 512;
      p    = base;
      nf   = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) begin
        tags[f] = $urandom_range(1, 60);
        ts = $sformatf("%0d", tags[f]);
        for (int k = 0; k < ts.len(); k++) begin
          mem[p] = ts[k];
          p++;
        end
        mem[p] = 8'h3D;
        p++;
        vl = $urandom_range(0, 4);
        repeat (vl) begin
          mem[p] = 8'h41 + 8'($urandom_range(0, 25));
          p++;
        end
        mem[p] = 8'h01;
        p++;
      end
      e = p - 1;
      if ($urandom_range(0, 2) == 0) e = e - $urandom_range(0, 3);
      if (e >= base && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       mem[base + $urandom_range(0, e - base)] = 8'h61;
          1:       mem[base + $urandom_range(0, e - base)] = 8'h3D;
          2:       mem[base + $urandom_range(0, e - base)] = 8'h01;
          default: mem[base + $urandom_range(0, e - base)] = 8'h37;
        endcase
      end
      if ($urandom_range(0, 1) == 1) tgt = tags[$urandom_range(0, nf - 1)];
      else tgt = $urandom_range(1, 60);
      x = model(tgt, base, e);
      run_search(tgt, base, e, o);
      expect_result($sformatf("rand%0d", it), o, x, base, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fix_tag_search.md
# fix_tag_search

Tag-lookup engine for the FIX parser: on a single-cycle search strobe it scans one stored FIX message (a byte range in the message buffer), parses `tag=value<SOH>` fields, and reports the location and length of the value of the requested tag. It sits directly downstream of the read-message controller, consuming its search strobe and the message start/end addresses fetched from the address-location tables. It drives the message buffer's read port.

## Interface
Parameters:
- TAG_WIDTH, 32, width of the binary tag number compared against parsed decimal tags
- ADDR_WIDTH, 10, message-buffer byte address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- search_tag_i  in  1  start strobe; sampled only in IDLE
- tag_i  in  TAG_WIDTH  target tag number (binary), latched with strobe
- start_addr_i  in  ADDR_WIDTH  first byte of message, latched with strobe
- end_addr_i  in  ADDR_WIDTH  last byte of message (inclusive), latched with strobe
- mem_rd_en_o  out  1  buffer read enable
- mem_addr_o  out  ADDR_WIDTH  buffer read address
- mem_rd_data_i  in  8  read data, valid exactly 1 cycle after mem_rd_en_o
- busy_o  out  1  high from cycle after accepted strobe until done_o
- done_o  out  1  one-cycle completion pulse
- found_o  out  1  target tag located (valid from done_o until next accepted strobe)
- error_o  out  1  malformed message or start_addr > end_addr
- value_start_o  out  ADDR_WIDTH  address of first value byte
- value_len_o  out  ADDR_WIDTH  value length in bytes (0 allowed)

## Operation
- States: IDLE, SCAN_TAG, SCAN_VALUE, FINISH.
- IDLE: on search_tag_i, latch tag_i/start/end, clear result outputs, clear accumulator. If start>end go FINISH with error_o=1, no reads issued; else go SCAN_TAG.
- Reads: one byte per cycle, mem_addr_o = start, start+1, … ; never beyond end_addr. Reads stop once termination is detected; at most one already-issued read past the terminating byte is discarded.
- SCAN_TAG, per returned byte b:
  - '0'..'9': acc <= acc*10 + (b-0x30), truncated modulo 2^TAG_WIDTH.
  - '=' : match <= (acc == latched tag, and ≥1 digit seen); value_start <= addr(b)+1; len <= 0; go SCAN_VALUE.
  - any other byte, or '=' with zero digits: terminate, error_o=1, found_o=0.
- SCAN_VALUE, per byte: SOH (0x01): if match terminate found_o=1; else acc<=0, go SCAN_TAG. Other byte: len <= len+1.
- Last byte (end_addr) processed without terminating: if in SCAN_VALUE with match, found_o=1 (value runs to end_addr); otherwise found_o=0, error_o=0 (clean miss), except SCAN_TAG with digits pending is also a clean miss.
- FINISH: pulse done_o one cycle, return to IDLE. Results held until next accepted strobe.
- First match wins; later duplicate tags ignored.

## Timing
- Reset: all outputs 0, state IDLE, effective next cycle; rst mid-scan aborts with no done_o.
- Strobe sampled at edge of cycle 0; mem_rd_en_o=1, mem_addr_o=start in cycle 1; byte k (offset from start) on mem_rd_data_i in cycle k+2.
- Terminating byte at offset k: done_o and final results in cycle k+3; busy_o high cycles 1..k+2.
- Full miss over N bytes: done_o in cycle N+2.
- start>end: done_o in cycle 2, error_o=1, mem_rd_en_o never asserted.
- search_tag_i while busy_o or during done_o cycle: ignored.

## Test plan
Buffer at 0x000: "8=FIX.4.2<SOH>35=D<SOH>49=ABC<SOH>" (offsets 0–21), start=0, end=21.
- tag 35 -> done_o cycle 17, found_o=1, value_start_o=13, value_len_o=1, error_o=0.
- tag 49 -> done_o cycle 24, found_o=1, value_start_o=18, value_len_o=3.
- tag 52 -> done_o cycle 24, found_o=0, error_o=0; no read address >21.
- Message "58=<SOH>" at 0x100, end 0x103, tag 58 -> found_o=1, value_start_o=0x103, value_len_o=0; "3a=X<SOH>" -> error_o=1 at done_o cycle 4.
- start=5, end=4 -> done_o cycle 2, error_o=1, no reads; rst in cycle 6 of a tag-49 search -> outputs 0 next cycle, no done_o, new strobe accepted normally.
- Strobe repeated while busy_o -> ignored, latched tag unchanged, single done_o.
